// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of a single-access SDRAM controller.
// Only one access is outstanding at a time. Completion is detected on the
// rising edge of the controller's done levels. A stalled access is aborted
// after TIMEOUT cycles and reported with err.
module sdram_arbiter #(
    parameter int unsigned INIT_WAIT = 16400,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        CLOCK_50,
    input  logic        rst,

    input  logic [23:0] p0_addr,
    input  logic        p0_rd,
    input  logic        p0_wr,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_ack,
    output logic        p0_err,

    input  logic [23:0] p1_addr,
    input  logic        p1_rd,
    input  logic        p1_wr,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_ack,
    output logic        p1_err,

    output logic [23:0] address,
    output logic        req_read,
    output logic        req_write,
    output logic [31:0] data_in,
    input  logic [31:0] data_out,
    input  logic        data_valid,
    input  logic        write_complete
);

    localparam int unsigned IW = (INIT_WAIT < 2) ? 1 : $clog2(INIT_WAIT + 1);
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [IW-1:0]   init_cnt;
    logic [TW-1:0]   to_cnt;
    logic            owner;        // 0 = port 0, 1 = port 1
    logic            op_rd;        // latched operation of the current access
    logic            last_served;  // port acked most recently
    logic            dv_prev;
    logic            wc_prev;

    logic            req0;
    logic            req1;
    logic            pick1;
    logic            pick_rd;
    logic            done;
    logic            init_done;
    logic            timed_out;

    // Request decode and round-robin pick: the port not served last wins a tie.
    assign req0      = p0_rd | p0_wr;
    assign req1      = p1_rd | p1_wr;
    assign pick1     = req1 & (~req0 | ~last_served);
    assign pick_rd   = pick1 ? p1_rd : p0_rd;

    // Completion is an edge of the signal matching the op; the other is ignored.
    assign done      = op_rd ? (data_valid & ~dv_prev) : (write_complete & ~wc_prev);
    assign init_done = (32'(init_cnt) + 32'd1) >= INIT_WAIT;
    assign timed_out = (32'(to_cnt) + 32'd1) >= TIMEOUT;

    // Previous-value flops for completion edge detection, updated every cycle.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            dv_prev <= 1'b0;
            wc_prev <= 1'b0;
        end else begin
            dv_prev <= data_valid;
            wc_prev <= write_complete;
        end
    end

    // Arbitration FSM with registered controller and port outputs.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state       <= S_INIT;
            init_cnt    <= '0;
            to_cnt      <= '0;
            owner       <= 1'b0;
            op_rd       <= 1'b0;
            last_served <= 1'b1;
            req_read    <= 1'b0;
            req_write   <= 1'b0;
            address     <= '0;
            data_in     <= '0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_err      <= 1'b0;
            p1_err      <= 1'b0;
        end else begin
            req_read  <= 1'b0;
            req_write <= 1'b0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;

            case (state)
                S_INIT: begin
                    if (init_done) begin
                        state <= S_IDLE;
                    end else begin
                        init_cnt <= init_cnt + IW'(1);
                    end
                end

                S_IDLE: begin
                    if (req0 | req1) begin
                        owner     <= pick1;
                        op_rd     <= pick_rd;
                        address   <= pick1 ? p1_addr : p0_addr;
                        data_in   <= pick1 ? p1_wdata : p0_wdata;
                        req_read  <= pick_rd;
                        req_write <= ~pick_rd;
                        state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end

                S_WAIT: begin
                    if (done) begin
                        if (owner) begin
                            p1_ack <= 1'b1;
                            if (op_rd) p1_rdata <= data_out;
                        end else begin
                            p0_ack <= 1'b1;
                            if (op_rd) p0_rdata <= data_out;
                        end
                        state <= S_RESP;
                    end else if (timed_out) begin
                        if (owner) begin
                            p1_ack <= 1'b1;
                            p1_err <= 1'b1;
                        end else begin
                            p0_ack <= 1'b1;
                            p0_err <= 1'b1;
                        end
                        state <= S_RESP;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end

                S_RESP: begin
                    last_served <= owner;
                    state       <= S_IDLE;
                end

                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- INIT_WAIT, 16400: CLOCK_50 cycles after reset before the first request is issued; covers controller power-up init.
- TIMEOUT, 64: CLOCK_50 cycles allowed in WAIT before the access is aborted with error.

REQ-002 The block SHALL have one clock and a synchronous, active-high reset. Ports (name, direction, width, meaning):
- CLOCK_50, in, 1: sole clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- p0_addr, in, 24: port 0 word address.
- p0_rd, in, 1: port 0 read request; held until p0_ack.
- p0_wr, in, 1: port 0 write request; held until p0_ack.
- p0_wdata, in, 32: port 0 write data.
- p0_rdata, out, 32: port 0 read data; valid when p0_ack=1.
- p0_ack, out, 1: port 0 one-cycle completion pulse.
- p0_err, out, 1: port 0 timeout flag; qualified by p0_ack.
- p1_addr, p1_rd, p1_wr, p1_wdata, p1_rdata, p1_ack, p1_err: same as port 0, for port 1.
- address, out, 24: controller address.
- req_read, out, 1: controller read request pulse.
- req_write, out, 1: controller write request pulse.
- data_in, out, 32: controller write data.
- data_out, in, 32: controller read data.
- data_valid, in, 1: controller read-done level.
- write_complete, in, 1: controller write-done level.

Function
REQ-003 FSM states SHALL be INIT, IDLE, ISSUE, WAIT, RESP.
REQ-004 INIT SHALL count INIT_WAIT cycles, then go to IDLE. Port requests held during INIT SHALL stay pending and SHALL NOT be acked.
REQ-005 IDLE SHALL grant one requesting port using round-robin priority: the port not served last wins a tie; after reset, port 0 has priority.
REQ-006 On grant, the block SHALL latch address, data_in, op and owner in the same cycle and go to ISSUE. If both rd and wr are set on one port, rd SHALL win.
REQ-007 ISSUE SHALL assert exactly one of req_read/req_write for exactly one CLOCK_50 cycle, then go to WAIT. A longer pulse risks a duplicate controller access and is forbidden.
REQ-008 address and data_in SHALL hold the latched values from ISSUE through RESP inclusive, because the controller samples them late.
REQ-009 data_valid and write_complete SHALL each pass through a one-flop previous-value register, updated every cycle in every state. Completion SHALL be the rising edge (current=1, previous=0); level alone SHALL NOT complete an access.
REQ-010 WAIT, read op: on a data_valid rising edge, capture data_out into the owner's rdata register and go to RESP.
REQ-011 WAIT, write op: on a write_complete rising edge, go to RESP. Edges of the signal that does not match the op SHALL be ignored.
REQ-012 A WAIT cycle counter SHALL clear on entry to WAIT. When it reaches TIMEOUT-1 with no completion, the FSM SHALL go to RESP with error set; rdata SHALL stay unchanged. A completion edge and timeout in the same cycle SHALL count as success.
REQ-013 RESP SHALL pulse the owner's ack for one cycle, plus err if the access timed out, and record the owner as last served. The other port's ack/err SHALL stay 0. Next state: IDLE.
REQ-014 A new grant SHALL NOT occur in the RESP cycle; minimum request-to-ack latency is 4 cycles (IDLE, ISSUE, WAIT, RESP).
REQ-015 p0_rdata and p1_rdata SHALL hold their value until their own port's next successful read.
REQ-016 Only one access SHALL be outstanding at any time; a port SHALL never receive two acks for one request.
REQ-017 The timeout counter SHALL be wide enough for TIMEOUT and SHALL saturate; it SHALL not wrap.

Reset
REQ-018 On rst=1, all of the following SHALL take effect on the next edge: FSM=INIT; init counter=0; timeout counter=0; req_read=0, req_write=0; address=0, data_in=0; p0_rdata=0, p1_rdata=0; acks=0, errs=0; edge-detect flops=0; last-served=port 1, so port 0 is favoured.
REQ-019 Reset asserted mid-access SHALL abandon the access without any ack. After release, the block SHALL re-run INIT.

Verification
REQ-020 Reset, then hold p0_rd=1 with p0_addr=0x000123 from cycle 0 -> no req_read before cycle INIT_WAIT; then exactly one req_read pulse with address=0x000123.
REQ-021 Port 0 write of 0xDEADBEEF to 0x000010. Model asserts write_complete high for 3 cycles -> p0_ack pulses exactly once, p0_err=0, data_in=0xDEADBEEF held throughout.
REQ-022 p0_rd and p1_rd asserted in the same cycle, both held after their acks -> grants alternate 0,1,0,1; each ack is 1 cycle.
REQ-023 Read with the model never raising data_valid (TIMEOUT=64) -> p0_ack=1 and p0_err=1 exactly 64 cycles after WAIT entry; p0_rdata unchanged.
REQ-024 Port 1 read, model returns 0x12345678 with data_valid high 2 cycles -> p1_rdata=0x12345678; one p1_ack; p0_ack stays 0.
REQ-025 rst pulsed during WAIT of a read -> no ack; req_read=0; FSM returns to INIT; a later request is served normally.
